// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A interrupt acknowledge sequencer.
//   state_e        : acknowledge FSM states
//   IR_COUNT       : number of interrupt request lines
//   SPURIOUS_INDEX : IR index reported when a request is withdrawn before INTA
//   highest_set    : highest-priority set bit under circular priority
//   prio_rank      : priority rank of an IR index (0 = highest)
package pic_pkg;

  localparam int         IR_COUNT       = 8;
  localparam logic [2:0] SPURIOUS_INDEX = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    WAIT2,
    VEC
  } state_e;

  // Returns {found, index}. Lines are scanned from lowest to highest
  // priority so the highest-priority hit overwrites any earlier one.
  function automatic logic [3:0] highest_set(input logic [7:0] vec,
                                             input logic [2:0] zero_level);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = IR_COUNT - 1; k >= 0; k--) begin
      idx = zero_level + 3'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Distance from the zero-level line; the 3-bit subtraction wraps mod 8.
  function automatic logic [2:0] prio_rank(input logic [2:0] idx,
                                           input logic [2:0] zero_level);
    return idx - zero_level;
  endfunction

endpackage

// File: rtl/priority_select.sv
// Combinational priority resolver.
//   candidate_i  : unmasked pending requests
//   isr_i        : current in-service bits
//   zero_level_i : IR line holding highest priority
//   win_valid_o  : a candidate outranks every in-service line
//   win_index_o  : IR index of the highest-priority candidate
module priority_select
  import pic_pkg::*;
(
  input  logic [7:0] candidate_i,
  input  logic [7:0] isr_i,
  input  logic [2:0] zero_level_i,
  output logic       win_valid_o,
  output logic [2:0] win_index_o
);

  logic [3:0] cand_top;
  logic [3:0] isr_top;

  assign cand_top = highest_set(candidate_i, zero_level_i);
  assign isr_top  = highest_set(isr_i, zero_level_i);

  // Strictly higher priority than the top in-service line; an equal rank
  // means the same line is already being serviced.
  assign win_valid_o = cand_top[3] &&
                       (!isr_top[3] ||
                        (prio_rank(cand_top[2:0], zero_level_i) <
                         prio_rank(isr_top[2:0], zero_level_i)));
  assign win_index_o = cand_top[2:0];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A interrupt acknowledge sequencer: resolves the winning IR line,
// raises INT, runs the two-pulse INTA handshake and drives the vector.
//   clk, reset        : clock, synchronous active-high reset
//   interAck_n        : CPU INTA (active low, asynchronous)
//   initDone          : ICW sequence complete; 0 forces IDLE
//   irrValue/imrValue/isrValue : request, mask and in-service vectors
//   zeroLevelIndex    : IR line with highest priority
//   vectorBase        : ICW2[7:3]
//   aeoiMode          : automatic EOI enabled
//   INT               : interrupt request to CPU
//   isrSet/irrClear/eoiClear : one-cycle update pulses for ackIndex
//   ackIndex          : IR index being acknowledged
//   dataOut/dataEnable: vector byte and bus drive enable
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interAck_n,
  input  logic       initDone,
  input  logic [7:0] irrValue,
  input  logic [7:0] imrValue,
  input  logic [7:0] isrValue,
  input  logic [2:0] zeroLevelIndex,
  input  logic [4:0] vectorBase,
  input  logic       aeoiMode,
  output logic       INT,
  output logic       isrSet,
  output logic       irrClear,
  output logic       eoiClear,
  output logic [2:0] ackIndex,
  output logic [7:0] dataOut,
  output logic       dataEnable
);

  logic [SYNC_STAGES-1:0] inta_sync_q;
  logic                   inta_prev_q;
  logic                   inta_now;
  logic                   inta_fall;
  logic                   inta_rise;

  logic [7:0] candidate;
  logic       win_valid;
  logic [2:0] win_index;

  state_e     state_q, state_d;
  logic       int_q, int_d;
  logic       isr_set_q, isr_set_d;
  logic       irr_clear_q, irr_clear_d;
  logic       eoi_clear_q, eoi_clear_d;
  logic [2:0] ack_index_q, ack_index_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_en_q, data_en_d;
  logic       spurious_q, spurious_d;

  // INTA idles high, so the synchroniser resets to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      inta_sync_q <= '1;
      inta_prev_q <= 1'b1;
    end else begin
      inta_sync_q[0] <= interAck_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        inta_sync_q[s] <= inta_sync_q[s-1];
      end
      inta_prev_q <= inta_now;
    end
  end

  assign inta_now  = inta_sync_q[SYNC_STAGES-1];
  assign inta_fall = inta_prev_q & ~inta_now;
  assign inta_rise = ~inta_prev_q & inta_now;

  assign candidate = irrValue & ~imrValue;

  priority_select u_priority_select (
    .candidate_i  (candidate),
    .isr_i        (isrValue),
    .zero_level_i (zeroLevelIndex),
    .win_valid_o  (win_valid),
    .win_index_o  (win_index)
  );

  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    isr_set_d   = 1'b0;
    irr_clear_d = 1'b0;
    eoi_clear_d = 1'b0;
    ack_index_d = ack_index_q;
    data_out_d  = data_out_q;
    data_en_d   = data_en_q;
    spurious_d  = spurious_q;

    if (!initDone) begin
      state_d     = IDLE;
      int_d       = 1'b0;
      ack_index_d = 3'd0;
      data_out_d  = 8'd0;
      data_en_d   = 1'b0;
      spurious_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          int_d     = 1'b0;
          data_en_d = 1'b0;
          if (win_valid) begin
            state_d = REQ;
            int_d   = 1'b1;
          end
        end
        REQ: begin
          int_d = 1'b1;
          // Winner is sampled only at the first INTA; a withdrawn request
          // is acknowledged as spurious IR7.
          if (inta_fall) begin
            int_d   = 1'b0;
            state_d = ACK1;
            if (win_valid) begin
              ack_index_d = win_index;
              isr_set_d   = 1'b1;
              irr_clear_d = 1'b1;
              spurious_d  = 1'b0;
            end else begin
              ack_index_d = SPURIOUS_INDEX;
              spurious_d  = 1'b1;
            end
          end
        end
        ACK1: begin
          if (inta_rise) state_d = WAIT2;
        end
        WAIT2: begin
          if (inta_fall) begin
            state_d    = VEC;
            data_out_d = {vectorBase, ack_index_q};
            data_en_d  = 1'b1;
          end
        end
        VEC: begin
          if (inta_rise) begin
            state_d     = IDLE;
            data_en_d   = 1'b0;
            data_out_d  = 8'd0;
            eoi_clear_d = aeoiMode & ~spurious_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      int_q       <= 1'b0;
      isr_set_q   <= 1'b0;
      irr_clear_q <= 1'b0;
      eoi_clear_q <= 1'b0;
      ack_index_q <= 3'd0;
      data_out_q  <= 8'd0;
      data_en_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      isr_set_q   <= isr_set_d;
      irr_clear_q <= irr_clear_d;
      eoi_clear_q <= eoi_clear_d;
      ack_index_q <= ack_index_d;
      data_out_q  <= data_out_d;
      data_en_q   <= data_en_d;
      spurious_q  <= spurious_d;
    end
  end

  assign INT        = int_q;
  assign isrSet     = isr_set_q;
  assign irrClear   = irr_clear_q;
  assign eoiClear   = eoi_clear_q;
  assign ackIndex   = ack_index_q;
  assign dataOut    = data_out_q;
  assign dataEnable = data_en_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer (SYNC_STAGES = 2).
module tb_interrupt_ack_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, interAck_n, initDone, aeoiMode;
  logic [7:0] irrValue, imrValue, isrValue;
  logic [2:0] zeroLevelIndex;
  logic [4:0] vectorBase;
  logic       INT, isrSet, irrClear, eoiClear, dataEnable;
  logic [2:0] ackIndex;
  logic [7:0] dataOut;

  int checks = 0;
  int errors = 0;
  int excl_bad = 0;

  logic       saw_isr, saw_irr, saw_eoi, saw_den;
  logic [2:0] isr_idx, eoi_idx;
  logic [7:0] den_val;

  interrupt_ack_sequencer #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .interAck_n     (interAck_n),
    .initDone       (initDone),
    .irrValue       (irrValue),
    .imrValue       (imrValue),
    .isrValue       (isrValue),
    .zeroLevelIndex (zeroLevelIndex),
    .vectorBase     (vectorBase),
    .aeoiMode       (aeoiMode),
    .INT            (INT),
    .isrSet         (isrSet),
    .irrClear       (irrClear),
    .eoiClear       (eoiClear),
    .ackIndex       (ackIndex),
    .dataOut        (dataOut),
    .dataEnable     (dataEnable)
  );

  // {INT, isrSet, irrClear, eoiClear, ackIndex, dataOut, dataEnable}
  logic [15:0] obs;
  assign obs = {INT, isrSet, irrClear, eoiClear, ackIndex, dataOut, dataEnable};

  typedef struct {
    logic        rst;
    logic        inta;
    logic [7:0]  irr;
    logic [7:0]  isr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [15:0] ex(input logic i, input logic s, input logic c,
                                     input logic e, input logic [2:0] a,
                                     input logic [7:0] d, input logic en);
    return {i, s, c, e, a, d, en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic observe();
    if (isrSet) begin saw_isr = 1'b1; isr_idx = ackIndex; end
    if (irrClear) saw_irr = 1'b1;
    if (eoiClear) begin saw_eoi = 1'b1; eoi_idx = ackIndex; end
    if (dataEnable) begin saw_den = 1'b1; den_val = dataOut; end
    if (eoiClear && (isrSet || irrClear)) excl_bad++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic phase(input logic level, input int n);
    interAck_n = level;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic handshake();
    saw_isr = 1'b0; saw_irr = 1'b0; saw_eoi = 1'b0; saw_den = 1'b0;
    isr_idx = 3'd0; eoi_idx = 3'd0; den_val = 8'd0;
    phase(1'b0, 4);
    phase(1'b1, 4);
    phase(1'b0, 4);
    phase(1'b1, 4);
  endtask

  task automatic do_reset();
    reset = 1'b1; interAck_n = 1'b1; initDone = 1'b1;
    irrValue = 8'h00; imrValue = 8'h00; isrValue = 8'h00;
    zeroLevelIndex = 3'd0; aeoiMode = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vectorBase = 5'b01000;
    do_reset();

    // IR3 full handshake, cycle by cycle (inputs applied, then one clock).
    tbl[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, ex(0,0,0,0,3'd0,8'h00,0)};
    tbl[1]  = '{1'b0, 1'b1, 8'h08, 8'h00, ex(1,0,0,0,3'd0,8'h00,0)};
    tbl[2]  = '{1'b0, 1'b0, 8'h08, 8'h00, ex(1,0,0,0,3'd0,8'h00,0)};
    tbl[3]  = '{1'b0, 1'b0, 8'h08, 8'h00, ex(1,0,0,0,3'd0,8'h00,0)};
    tbl[4]  = '{1'b0, 1'b0, 8'h08, 8'h00, ex(0,1,1,0,3'd3,8'h00,0)};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h00,0)};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h00,0)};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h00,0)};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h00,0)};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h00,0)};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h43,1)};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h43,1)};
    tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h43,1)};
    tbl[13] = '{1'b0, 1'b1, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h43,1)};
    tbl[14] = '{1'b0, 1'b1, 8'h00, 8'h08, ex(0,0,0,0,3'd3,8'h00,0)};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 8'h00, ex(0,0,0,0,3'd3,8'h00,0)};

    for (int i = 0; i < 16; i++) begin
      reset      = tbl[i].rst;
      interAck_n = tbl[i].inta;
      irrValue   = tbl[i].irr;
      isrValue   = tbl[i].isr;
      step();
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // In-service IR2 blocks IR5 at zero level 0, not at zero level 4.
    do_reset();
    isrValue = 8'h04; irrValue = 8'h20;
    step(); step(); step();
    chk("isr_blocks_int", 32'(INT), 32'd0);
    zeroLevelIndex = 3'd4;
    step();
    chk("rotated_int", 32'(INT), 32'd1);
    handshake();
    chk("rotated_isrset", 32'(saw_isr), 32'd1);
    chk("rotated_ack", 32'(isr_idx), 32'd5);
    chk("rotated_vector", 32'(den_val), 32'h45);

    // Masked request never raises INT.
    do_reset();
    irrValue = 8'h02; imrValue = 8'h02;
    step(); step();
    chk("masked_int", 32'(INT), 32'd0);

    // AEOI clears IR1 on the second INTA rise.
    do_reset();
    irrValue = 8'h02; aeoiMode = 1'b1;
    step();
    chk("aeoi_int", 32'(INT), 32'd1);
    handshake();
    chk("aeoi_eoi", 32'(saw_eoi), 32'd1);
    chk("aeoi_eoi_idx", 32'(eoi_idx), 32'd1);
    chk("aeoi_vector", 32'(den_val), 32'h41);

    // Without AEOI there is no eoiClear.
    do_reset();
    irrValue = 8'h02;
    step();
    handshake();
    chk("noaeoi_isrset", 32'(saw_isr), 32'd1);
    chk("noaeoi_eoi", 32'(saw_eoi), 32'd0);

    // IR6 withdrawn before the first INTA: spurious IR7.
    do_reset();
    irrValue = 8'h40; aeoiMode = 1'b1;
    step();
    chk("spur_int", 32'(INT), 32'd1);
    irrValue = 8'h00;
    handshake();
    chk("spur_isrset", 32'(saw_isr), 32'd0);
    chk("spur_irrclear", 32'(saw_irr), 32'd0);
    chk("spur_vector", 32'(den_val), 32'h47);
    chk("spur_eoi", 32'(saw_eoi), 32'd0);
    chk("spur_ack", 32'(ackIndex), 32'd7);

    // Reset during vector drive abandons it; later INTAs are ignored.
    do_reset();
    irrValue = 8'h08;
    step();
    phase(1'b0, 4);
    phase(1'b1, 4);
    phase(1'b0, 4);
    chk("vec_drive_before_reset", 32'({dataEnable, dataOut}), 32'h143);
    reset = 1'b1;
    step();
    chk("reset_mid_vec", 32'(obs), 32'd0);
    reset = 1'b0; irrValue = 8'h00;
    phase(1'b1, 4);
    handshake();
    chk("post_reset_nodrive", 32'(saw_den), 32'd0);
    chk("post_reset_noisr", 32'(saw_isr), 32'd0);

    // initDone gates the request and aborts a handshake.
    do_reset();
    initDone = 1'b0; irrValue = 8'h01;
    step(); step(); step();
    chk("noinit_int", 32'(INT), 32'd0);
    initDone = 1'b1;
    step();
    chk("init_int", 32'(INT), 32'd1);
    phase(1'b0, 4);
    phase(1'b1, 4);
    phase(1'b0, 4);
    chk("init_vec_drive", 32'(dataEnable), 32'd1);
    initDone = 1'b0;
    step();
    chk("init_abort", 32'(obs), 32'd0);

    chk("pulse_exclusive", 32'(excl_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
